// File: rtl/bf_pkg.sv
// Shared brainfuck core definitions: opcode encoding and loop-controller FSM states.
package bf_pkg;

   typedef enum logic [2:0] {
      OP_INC   = 3'd0,
      OP_DEC   = 3'd1,
      OP_RIGHT = 3'd2,
      OP_LEFT  = 3'd3,
      OP_JZ    = 3'd4,
      OP_JNZ   = 3'd5,
      OP_OUT   = 3'd6,
      OP_IN    = 3'd7
   } bf_op_e;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SCAN_REQ = 2'd1,
      SCAN_CHK = 2'd2
   } lc_state_e;

endpackage

// File: rtl/bf_lifo.sv
// Return-address stack for loop starts; top_out reads the newest entry combinationally.
module bf_lifo #(
   parameter int  DEPTH  = 16,
   parameter int  ADDR_W = 16,
   localparam int CW     = $clog2(DEPTH + 1)
) (
   input  logic              clk_in,
   input  logic              reset_in,
   input  logic              push_in,
   input  logic              pop_in,
   input  logic [ADDR_W-1:0] data_in,
   output logic [ADDR_W-1:0] top_out,
   output logic              full_out,
   output logic              empty_out,
   output logic [CW-1:0]     count_out
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [ADDR_W-1:0] mem_q [DEPTH];
   logic [CW-1:0]     count_q, count_d;
   logic [CW-1:0]     top_idx;

   assign full_out  = (count_q == CW'(DEPTH));
   assign empty_out = (count_q == '0);
   assign top_idx   = count_q - CW'(1);
   assign top_out   = empty_out ? '0 : mem_q[top_idx[IW-1:0]];
   assign count_out = count_q;

   always_comb begin
      count_d = count_q;
      if (push_in && !full_out) begin
         count_d = count_q + CW'(1);
      end else if (pop_in && !empty_out) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Entry storage needs no reset: count_q alone decides which entries are live.
   always_ff @(posedge clk_in) begin
      if (push_in && !full_out) begin
         mem_q[count_q[IW-1:0]] <= data_in;
      end
   end

endmodule

// File: rtl/bf_loop_ctrl.sv
// Resolves "[" and "]" for the sequencer: return stack for loop starts, forward
// bracket scan through instruction memory when a loop is skipped.
module bf_loop_ctrl
   import bf_pkg::*;
#(
   parameter int  ADDR_W = 16,
   parameter int  DEPTH  = 16,
   localparam int DW     = $clog2(DEPTH + 1)
) (
   input  logic              clk_in,
   input  logic              reset_in,
   input  logic              op_valid_in,
   input  logic [2:0]        op_in,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic              cell_zero_in,
   output logic              op_ready_out,
   output logic              done_out,
   output logic [ADDR_W-1:0] next_pc_out,
   output logic              fetch_req_out,
   output logic [ADDR_W-1:0] fetch_addr_out,
   input  logic [2:0]        fetch_op_in,
   output logic [DW-1:0]     depth_out,
   output logic              err_overflow_out,
   output logic              err_unmatched_out,
   output logic [1:0]        dbg_state_out
);

   // Handshake: an op transfers on a rising edge where op_valid_in && op_ready_out;
   // the sequencer holds the op stable until op_ready_out is seen high.

   lc_state_e         state_q, state_d;
   logic [ADDR_W-1:0] scan_addr_q, scan_addr_d;
   logic [ADDR_W-1:0] scan_depth_q, scan_depth_d;
   logic [ADDR_W-1:0] next_pc_q, next_pc_d;
   logic              done_q, done_d;
   logic              scan_end_q, scan_end_d;
   logic              err_ovf_q, err_ovf_d;
   logic              err_unm_q, err_unm_d;

   logic              push, pop, full, empty;
   logic [ADDR_W-1:0] top, pc_inc, scan_inc, depth_chk;
   logic              accept;

   assign op_ready_out = (state_q == IDLE) && !scan_end_q;
   assign accept       = op_valid_in && op_ready_out;
   assign pc_inc       = pc_in + ADDR_W'(1);
   assign scan_inc     = scan_addr_q + ADDR_W'(1);

   always_comb begin
      state_d      = state_q;
      scan_addr_d  = scan_addr_q;
      scan_depth_d = scan_depth_q;
      next_pc_d    = next_pc_q;
      err_ovf_d    = err_ovf_q;
      err_unm_d    = err_unm_q;
      done_d       = 1'b0;
      scan_end_d   = 1'b0;
      push         = 1'b0;
      pop          = 1'b0;
      depth_chk    = scan_depth_q;
      case (state_q)
         IDLE: begin
            if (accept && op_in == OP_JZ) begin
               if (cell_zero_in) begin
                  scan_depth_d = ADDR_W'(1);
                  scan_addr_d  = pc_inc;
                  state_d      = SCAN_REQ;
               end else begin
                  push      = !full;
                  err_ovf_d = err_ovf_q | full;
                  next_pc_d = pc_inc;
                  done_d    = 1'b1;
               end
            end else if (accept && op_in == OP_JNZ) begin
               done_d    = 1'b1;
               next_pc_d = pc_inc;
               if (empty) begin
                  err_unm_d = 1'b1;
               end else if (cell_zero_in) begin
                  pop = 1'b1;
               end else begin
                  next_pc_d = top;
               end
            end
         end
         SCAN_REQ: state_d = SCAN_CHK;
         SCAN_CHK: begin
            if (fetch_op_in == OP_JZ) begin
               depth_chk = scan_depth_q + ADDR_W'(1);
            end else if (fetch_op_in == OP_JNZ) begin
               depth_chk = scan_depth_q - ADDR_W'(1);
            end
            scan_depth_d = depth_chk;
            // A match on the last address is still a match; only a miss there wraps.
            if (depth_chk == '0) begin
               next_pc_d  = scan_inc;
               done_d     = 1'b1;
               scan_end_d = 1'b1;
               state_d    = IDLE;
            end else if (scan_addr_q == '1) begin
               err_unm_d  = 1'b1;
               next_pc_d  = '0;
               done_d     = 1'b1;
               scan_end_d = 1'b1;
               state_d    = IDLE;
            end else begin
               scan_addr_d = scan_inc;
               state_d     = SCAN_REQ;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state_q      <= IDLE;
         scan_addr_q  <= '0;
         scan_depth_q <= '0;
         next_pc_q    <= '0;
         done_q       <= 1'b0;
         scan_end_q   <= 1'b0;
         err_ovf_q    <= 1'b0;
         err_unm_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         scan_addr_q  <= scan_addr_d;
         scan_depth_q <= scan_depth_d;
         next_pc_q    <= next_pc_d;
         done_q       <= done_d;
         scan_end_q   <= scan_end_d;
         err_ovf_q    <= err_ovf_d;
         err_unm_q    <= err_unm_d;
      end
   end

   bf_lifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_lifo (
      .clk_in    (clk_in),
      .reset_in  (reset_in),
      .push_in   (push),
      .pop_in    (pop),
      .data_in   (pc_inc),
      .top_out   (top),
      .full_out  (full),
      .empty_out (empty),
      .count_out (depth_out)
   );

   assign done_out          = done_q;
   assign next_pc_out       = next_pc_q;
   assign fetch_req_out     = (state_q == SCAN_REQ);
   assign fetch_addr_out    = scan_addr_q;
   assign err_overflow_out  = err_ovf_q;
   assign err_unmatched_out = err_unm_q;
   assign dbg_state_out     = state_q;

endmodule

// File: tb/tb_bf_loop_ctrl.sv
// Bench for bf_loop_ctrl: vector table for single-cycle ops, hand sequences for scans,
// mid-scan reset and back-to-back ops; next_pc checked by a done-driven scoreboard.
module tb_bf_loop_ctrl;
   import bf_pkg::*;

   localparam int ADDR_W = 16;
   localparam int DEPTH  = 4;
   localparam int DW     = $clog2(DEPTH + 1);

   logic              clk, rst;
   logic              op_valid_in;
   logic [2:0]        op_in;
   logic [ADDR_W-1:0] pc_in;
   logic              cell_zero_in;
   logic              op_ready_out, done_out, fetch_req_out;
   logic [ADDR_W-1:0] next_pc_out, fetch_addr_out;
   logic [2:0]        fetch_op_in;
   logic [DW-1:0]     depth_out;
   logic              err_overflow_out, err_unmatched_out;
   logic [1:0]        dbg_state_out;

   int tests_run = 0;
   int fail_cnt  = 0;
   logic [ADDR_W-1:0] exp_q[$];
   logic [2:0]        imem_lo [8];

   typedef struct {
      logic [2:0]        op;
      logic [ADDR_W-1:0] pc;
      logic              cz;
      logic              exp_done;
      logic [ADDR_W-1:0] exp_pc;
      logic [DW-1:0]     exp_depth;
      logic              exp_ovf;
      logic              exp_unm;
   } vec_t;
   vec_t vecs[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   bf_loop_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk_in            (clk),
      .reset_in          (rst),
      .op_valid_in       (op_valid_in),
      .op_in             (op_in),
      .pc_in             (pc_in),
      .cell_zero_in      (cell_zero_in),
      .op_ready_out      (op_ready_out),
      .done_out          (done_out),
      .next_pc_out       (next_pc_out),
      .fetch_req_out     (fetch_req_out),
      .fetch_addr_out    (fetch_addr_out),
      .fetch_op_in       (fetch_op_in),
      .depth_out         (depth_out),
      .err_overflow_out  (err_overflow_out),
      .err_unmatched_out (err_unmatched_out),
      .dbg_state_out     (dbg_state_out)
   );

   function automatic logic [2:0] imem_rd(input logic [ADDR_W-1:0] a);
      if (a < ADDR_W'(8)) return imem_lo[a[2:0]];
      return 3'd0;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) fetch_op_in <= 3'd0;
      else if (fetch_req_out) fetch_op_in <= imem_rd(fetch_addr_out);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every done pulse consumes the oldest expected next_pc.
   always @(negedge clk) begin
      if (!rst && done_out === 1'b1) begin
         if (exp_q.size() == 0) check("done_unexpected", 32'(done_out), 32'd0);
         else check("next_pc", 32'(next_pc_out), 32'(exp_q.pop_front()));
      end
   end

   function automatic vec_t mk(input int op, input int pc, input int cz, input int dn,
                               input int epc, input int dep, input int ovf, input int unm);
      vec_t v;
      v.op = 3'(op);  v.pc = ADDR_W'(pc);  v.cz = 1'(cz);  v.exp_done = 1'(dn);
      v.exp_pc = ADDR_W'(epc);  v.exp_depth = DW'(dep);  v.exp_ovf = 1'(ovf);  v.exp_unm = 1'(unm);
      return v;
   endfunction

   task automatic check_reset_vals(input string tag);
      check({tag, "_ready"},   32'(op_ready_out), 32'd1);
      check({tag, "_done"},    32'(done_out), 32'd0);
      check({tag, "_next_pc"}, 32'(next_pc_out), 32'd0);
      check({tag, "_freq"},    32'(fetch_req_out), 32'd0);
      check({tag, "_faddr"},   32'(fetch_addr_out), 32'd0);
      check({tag, "_depth"},   32'(depth_out), 32'd0);
      check({tag, "_ovf"},     32'(err_overflow_out), 32'd0);
      check({tag, "_unm"},     32'(err_unmatched_out), 32'd0);
   endtask

   task automatic apply_vec(input vec_t v, input int idx);
      @(negedge clk);
      op_valid_in = 1'b1;  op_in = v.op;  pc_in = v.pc;  cell_zero_in = v.cz;
      if (v.exp_done) exp_q.push_back(v.exp_pc);
      @(posedge clk);
      #1 op_valid_in = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_done", idx),  32'(done_out), 32'(v.exp_done));
      check($sformatf("v%0d_depth", idx), 32'(depth_out), 32'(v.exp_depth));
      check($sformatf("v%0d_ovf", idx),   32'(err_overflow_out), 32'(v.exp_ovf));
      check($sformatf("v%0d_unm", idx),   32'(err_unmatched_out), 32'(v.exp_unm));
      check($sformatf("v%0d_ready", idx), 32'(op_ready_out), 32'd1);
      if (!v.exp_done) check($sformatf("v%0d_pc_held", idx), 32'(next_pc_out), 32'(v.exp_pc));
   endtask

   task automatic run_scan(input logic [ADDR_W-1:0] pc, input int k, input logic [ADDR_W-1:0] exp_pc,
                           input logic [DW-1:0] exp_depth, input logic exp_unm);
      int cyc = 0;
      int done_cyc = -1;
      int nreq = 0;
      bit ready_bad = 1'b0;
      bit req_bad = 1'b0;
      @(negedge clk);
      op_valid_in = 1'b1;  op_in = 3'd4;  pc_in = pc;  cell_zero_in = 1'b1;
      exp_q.push_back(exp_pc);
      @(posedge clk);
      #1 op_valid_in = 1'b0;
      while (done_cyc < 0 && cyc < 4 * k + 8) begin
         @(negedge clk);
         cyc++;
         if (op_ready_out !== 1'b0) ready_bad = 1'b1;
         if (fetch_req_out === 1'b1) begin
            if (cyc % 2 == 0) req_bad = 1'b1;
            check("scan_fetch_addr", 32'(fetch_addr_out), 32'(pc + ADDR_W'(nreq + 1)));
            nreq++;
         end
         if (done_out === 1'b1) done_cyc = cyc;
      end
      check("scan_done_cycle", 32'(done_cyc), 32'(2 * k + 1));
      check("scan_ready_low", 32'(ready_bad), 32'd0);
      check("scan_req_odd", 32'(req_bad), 32'd0);
      check("scan_nreq", 32'(nreq), 32'(k));
      check("scan_depth", 32'(depth_out), 32'(exp_depth));
      check("scan_unm", 32'(err_unmatched_out), 32'(exp_unm));
   endtask

   initial begin
      imem_lo[0] = 3'd4;  imem_lo[1] = 3'd0;  imem_lo[2] = 3'd4;  imem_lo[3] = 3'd1;
      imem_lo[4] = 3'd5;  imem_lo[5] = 3'd2;  imem_lo[6] = 3'd5;  imem_lo[7] = 3'd6;

      // op, pc, cell_zero, done, next_pc, depth, ovf, unm
      vecs.push_back(mk(4, 10, 0, 1, 11, 1, 0, 0));
      vecs.push_back(mk(5, 20, 0, 1, 11, 1, 0, 0));
      vecs.push_back(mk(5, 20, 1, 1, 21, 0, 0, 0));
      vecs.push_back(mk(0, 30, 1, 0, 21, 0, 0, 0));
      vecs.push_back(mk(1, 30, 0, 0, 21, 0, 0, 0));
      vecs.push_back(mk(2, 31, 1, 0, 21, 0, 0, 0));
      vecs.push_back(mk(3, 31, 0, 0, 21, 0, 0, 0));
      vecs.push_back(mk(6, 32, 1, 0, 21, 0, 0, 0));
      vecs.push_back(mk(7, 32, 0, 0, 21, 0, 0, 0));
      vecs.push_back(mk(4, 0, 0, 1, 1, 1, 0, 0));
      vecs.push_back(mk(4, 1, 0, 1, 2, 2, 0, 0));
      vecs.push_back(mk(4, 2, 0, 1, 3, 3, 0, 0));
      vecs.push_back(mk(4, 3, 0, 1, 4, 4, 0, 0));
      vecs.push_back(mk(4, 4, 0, 1, 5, 4, 1, 0));
      vecs.push_back(mk(5, 40, 0, 1, 4, 4, 1, 0));
      vecs.push_back(mk(5, 50, 1, 1, 51, 3, 1, 0));
      vecs.push_back(mk(5, 51, 1, 1, 52, 2, 1, 0));
      vecs.push_back(mk(5, 52, 1, 1, 53, 1, 1, 0));
      vecs.push_back(mk(5, 53, 1, 1, 54, 0, 1, 0));
      vecs.push_back(mk(5, 60, 1, 1, 61, 0, 1, 1));
      vecs.push_back(mk(5, 70, 0, 1, 71, 0, 1, 1));

      rst = 1'b1;  op_valid_in = 1'b0;  op_in = 3'd0;  pc_in = '0;  cell_zero_in = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_vals("rst_held");
      rst = 1'b0;
      @(negedge clk);
      check_reset_vals("rst_rel");

      for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], i);

      // Skip a nested loop: "[" at 0 over 0..7 = 4,0,4,1,5,2,5,6.
      run_scan(16'd0, 6, 16'd7, DW'(0), 1'b1);

      // Reset in cycle 3 of a scan.
      @(negedge clk);
      op_valid_in = 1'b1;  op_in = 3'd4;  pc_in = 16'd0;  cell_zero_in = 1'b1;
      @(posedge clk);
      #1 op_valid_in = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1 check_reset_vals("midscan_rst");
      check("midscan_state", 32'(dbg_state_out), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      apply_vec(mk(4, 100, 0, 1, 101, 1, 0, 0), 100);

      // Back-to-back: push at 200, then "]" on the very next edge sees top 201.
      @(negedge clk);
      op_valid_in = 1'b1;  op_in = 3'd4;  pc_in = 16'd200;  cell_zero_in = 1'b0;
      exp_q.push_back(16'd201);
      @(posedge clk);
      #1 op_in = 3'd5;  pc_in = 16'd210;
      exp_q.push_back(16'd201);
      @(posedge clk);
      #1 op_valid_in = 1'b0;
      @(negedge clk);
      check("b2b_done", 32'(done_out), 32'd1);
      check("b2b_depth", 32'(depth_out), 32'd2);

      // Unmatched "[" near the top of memory wraps.
      run_scan(16'hFFF0, 15, 16'h0000, DW'(2), 1'b1);
      check("wrap_ovf", 32'(err_overflow_out), 32'd0);

      repeat (3) @(negedge clk);
      check("exp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
      $finish;
   end

endmodule

// File: doc/bf_loop_ctrl.md
# bf_loop_ctrl

Loop controller for the brainfuck core: resolves the two control-flow opcodes, 4 "[" and 5 "]", on behalf of the main instruction sequencer. It keeps a hardware return stack of loop-start addresses. When "[" is taken on a zero cell, it scans instruction memory forward, counting bracket depth. It returns the next command pointer to the sequencer over a one-shot valid/ready handshake.

## Interface
- ADDR_W, 16, command-pointer / instruction-address width
- DEPTH, 16, return-stack entries (maximum live nesting)
- clk_in  input  1  clock, rising edge
- reset_in  input  1  asynchronous, active-high reset
- op_valid_in  input  1  sequencer presents an opcode
- op_in  input  3  opcode (0 "+", 1 "-", 2 ">", 3 "<", 4 "[", 5 "]", 6 ".", 7 ",")
- pc_in  input  ADDR_W  address of the presented opcode
- cell_zero_in  input  1  current data cell == 0; sampled with the op
- op_ready_out  output  1  controller idle; accepts op
- done_out  output  1  one-cycle pulse: next_pc_out valid
- next_pc_out  output  ADDR_W  resolved next command pointer; held until next done
- fetch_req_out  output  1  scan read request to instruction memory
- fetch_addr_out  output  ADDR_W  scan read address
- fetch_op_in  input  3  instruction read data, valid the cycle after fetch_req_out
- depth_out  output  $clog2(DEPTH+1)  live stack entries
- err_overflow_out  output  1  sticky: push attempted while full
- err_unmatched_out  output  1  sticky: unmatched bracket

## Operation
- Reset values: op_ready_out 1; done_out 0; next_pc_out 0; fetch_req_out 0; fetch_addr_out 0; depth_out 0; both err outputs 0.
- Reset clears the stack, counters and errors, and returns the FSM to IDLE from any state, including mid-scan.
- An op is accepted when op_valid_in && op_ready_out at the rising edge. Ops other than 4 or 5 are ignored: no done pulse and no state change.
- FSM states: IDLE, SCAN_REQ, SCAN_CHK.
  - IDLE → IDLE with a done pulse for every resolved case below.
  - IDLE → SCAN_REQ for "[" with a zero cell.
  - SCAN_REQ → SCAN_CHK always.
  - SCAN_CHK → SCAN_REQ when there is no match.
  - SCAN_CHK → IDLE on a match or on wrap.
- "[" with a nonzero cell:
  - Push pc_in+1 and set next_pc = pc_in+1.
  - If the stack is full, set err_overflow, drop the push, and still set next_pc = pc_in+1.
- "[" with a zero cell:
  - Set the scan depth counter (ADDR_W bits) to 1 and the scan address to pc_in+1. The stack is untouched.
  - In each SCAN_CHK, check fetch_op_in: 4 increments depth; 5 decrements depth. Any other opcode leaves depth unchanged.
  - When depth reaches 0: next_pc = scan address + 1, done.
  - Otherwise: scan address + 1, then return to SCAN_REQ.
  - If the scan address wraps from all-ones to 0 before a match: set err_unmatched, next_pc = 0, done.
- "]" with a nonzero cell: next_pc = top of stack, with no pop. If the stack is empty: set err_unmatched, next_pc = pc_in+1.
- "]" with a zero cell: pop and set next_pc = pc_in+1. If the stack is empty: set err_unmatched, no pop, next_pc = pc_in+1.
- Address arithmetic is modulo 2^ADDR_W. Errors stay set until reset.
- op_valid_in held high during a scan is not accepted. The sequencer holds the op until op_ready_out is high again.

## Timing
- Cycles are counted from the acceptance edge, which is edge 0.
- Non-scan ops:
  - done_out is high in cycle 1.
  - op_ready_out stays high, so back-to-back ops are allowed in consecutive cycles.
  - A push or pop is visible on depth_out in cycle 1.
- Scan ops:
  - op_ready_out is low from cycle 1 until the done cycle, inclusive.
  - fetch_req_out is high in cycles 1, 3, 5, …; fetch_op_in is checked in cycles 2, 4, 6, ….
  - If k instructions are scanned, done_out is high in cycle 2k+1.
  - fetch_addr_out is valid whenever fetch_req_out is high. The top level muxes instruction-memory address to fetch_addr_out while op_ready_out is 0.
- A push in cycle n and a "]" accepted at the next edge sees the new top. The stack is written on the acceptance edge.

## Structure
- Shared package bf_pkg: opcode enum (OP_INC=0 … OP_IN=7, 3 bits) and the bf_loop_ctrl FSM state enum. The package is used by the sequencer and top as well.
- One sub-module, bf_lifo:
  - Parameters: DEPTH and ADDR_W.
  - Interface: push/pop/data_in, top_out, full_out, empty_out, count_out.
  - Push and pop in the same cycle are not issued by bf_loop_ctrl.
- The FSM, scan counter and error flags live in bf_loop_ctrl.

## Test plan
- Reset, then "[" at pc 10 with cell nonzero → done in cycle 1, next_pc 11, depth 1. Then "]" at pc 20 with cell nonzero → next_pc 11, depth 1. Then "]" at pc 20 with cell zero → next_pc 21, depth 0.
- Memory 0..7 = 4,0,4,1,5,2,5,6; "[" at pc 0 with cell zero → fetch addrs 1..6, done in cycle 13, next_pc 7, depth unchanged at 0.
- With DEPTH=4, five "[" ops with nonzero cell at pcs 0..4 → depth 4, err_overflow 1 after the fifth, fifth next_pc 5.
- "]" with cell zero on an empty stack → err_unmatched 1, next_pc pc+1. "[" with cell zero at pc 0xFFF0 and no "]" before wrap → err_unmatched, next_pc 0.
- Assert reset_in in cycle 3 of a scan → all outputs at reset values immediately, and the next op is accepted normally. Ops 0 to 3 and 6 to 7 presented → no done pulse and no depth change.
